user_sw_debounce: RTL and testbench

Input-conditioning stage directly upstream of the processor block: takes the raw, asynchronous DIP and push switch pins, synchronises them into the system clock domain, debounces each bit independently, and delivers clean levels plus single-cycle press/release/change pulses. The processor consumes the debounced levels in place of the raw pins, e.g. for the LED pattern, and can use the pulses for event-driven control.

---
 rtl/user_sw_debounce.sv | 76 +++++++
 tb/tb_user_sw_debounce.sv | 139 +++++++++++++
 2 files changed

// File: rtl/user_sw_debounce.sv
// user_sw_debounce: synchronise, polarity-normalise and debounce 4 DIP + 4 push switches, with edge pulses
module user_sw_debounce #(
    parameter int pStableCycles  = 500000,
    parameter bit pPushActiveLow = 1'b1,
    parameter bit pDipActiveLow  = 1'b0
) (
    input  logic       iSysClk,
    input  logic       iSysRst,
    input  logic [3:0] iUserDipSw,
    input  logic [3:0] iUserPushSw,
    output logic [3:0] oUserDipSw,
    output logic [3:0] oUserPushSw,
    output logic [3:0] oPushPress,
    output logic [3:0] oPushRelease,
    output logic [3:0] oDipChange
);
    localparam int CW = $clog2(pStableCycles + 1);
    localparam logic [CW-1:0] LAST = CW'(pStableCycles - 1);
    localparam logic [7:0] INV = {{4{pPushActiveLow}}, {4{pDipActiveLow}}};

    logic [7:0] sync1_q, sync1_d, sync2_q, sync2_d, state_q, state_d;
    logic [7:0] sample, mis, acc;
    logic [7:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0] vld_q, vld_d;
    logic [3:0] press_q, press_d, release_q, release_d, change_q, change_d;

    // per-channel debounce; vld_q holds off counting until the synchroniser carries real pin data after reset
    always_comb begin
        sync1_d   = {iUserPushSw, iUserDipSw};
        sync2_d   = sync1_q;
        vld_d     = {vld_q[0], 1'b1};
        sample    = sync2_q ^ INV;
        mis       = '0;
        acc       = '0;
        cnt_d     = '0;
        state_d   = state_q;
        for (int i = 0; i < 8; i++) begin
            mis[i]     = vld_q[1] & (sample[i] ^ state_q[i]);
            acc[i]     = mis[i] & (cnt_q[i] == LAST);
            cnt_d[i]   = (mis[i] & ~acc[i]) ? cnt_q[i] + CW'(1) : '0;
            state_d[i] = acc[i] ? sample[i] : state_q[i];
        end
        press_d   = acc[7:4] & sample[7:4];
        release_d = acc[7:4] & ~sample[7:4];
        change_d  = acc[3:0];
    end

    // register stage for synchroniser, debounce state, counters and pulses
    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            vld_q     <= '0;
            state_q   <= '0;
            cnt_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            change_q  <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            vld_q     <= vld_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            change_q  <= change_d;
        end
    end

    assign oUserDipSw   = state_q[3:0];
    assign oUserPushSw  = state_q[7:4];
    assign oPushPress   = press_q;
    assign oPushRelease = release_q;
    assign oDipChange   = change_q;
endmodule

// File: tb/tb_user_sw_debounce.sv
// tb_user_sw_debounce: directed checks of latency, glitch rejection, pulses and reset for user_sw_debounce
module tb_user_sw_debounce;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dip_i = 4'h0;
    logic [3:0] push_i = 4'hF;
    logic [3:0] dip_o, push_o, press_o, release_o, change_o;
    logic [19:0] o;
    int checks = 0;
    int errors = 0;

    user_sw_debounce #(.pStableCycles(4)) dut (
        .iSysClk(clk),
        .iSysRst(rst),
        .iUserDipSw(dip_i),
        .iUserPushSw(push_i),
        .oUserDipSw(dip_o),
        .oUserPushSw(push_o),
        .oPushPress(press_o),
        .oPushRelease(release_o),
        .oDipChange(change_o)
    );

    assign o = {dip_o, push_o, press_o, release_o, change_o};

    always #5 clk = ~clk;

    function automatic logic [19:0] e(input logic [3:0] d, p, pr, rl, ch);
        return {d, p, pr, rl, ch};
    endfunction

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(3);
        check("rst", o, '0);
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            check("idle", o, '0);
        end
        push_i = 4'b1011;
        tick(5);
        check("press_pre", o, '0);
        tick();
        check("press", o, e(4'h0, 4'b0100, 4'b0100, 4'h0, 4'h0));
        tick();
        check("press_post", o, e(4'h0, 4'b0100, 4'h0, 4'h0, 4'h0));
        push_i = 4'hF;
        tick(5);
        check("rel_pre", o, e(4'h0, 4'b0100, 4'h0, 4'h0, 4'h0));
        tick();
        check("rel", o, e(4'h0, 4'h0, 4'h0, 4'b0100, 4'h0));
        tick();
        check("rel_post", o, '0);
        for (int k = 0; k < 10; k++) begin
            dip_i = 4'h1;
            for (int j = 0; j < 3; j++) begin
                tick();
                check("bounce_hi", o, '0);
            end
            dip_i = 4'h0;
            tick();
            check("bounce_lo", o, '0);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            check("bounce_hold", o, '0);
        end
        dip_i = 4'h1;
        tick(5);
        check("dip_pre", o, '0);
        tick();
        check("dip_acc", o, e(4'h1, 4'h0, 4'h0, 4'h0, 4'h1));
        tick();
        check("dip_post", o, e(4'h1, 4'h0, 4'h0, 4'h0, 4'h0));
        dip_i = 4'b0011;
        tick(3);
        dip_i = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("thr3_rej", o, e(4'h1, 4'h0, 4'h0, 4'h0, 4'h0));
        end
        dip_i = 4'b0011;
        tick(4);
        check("thr4_pre", o, e(4'h1, 4'h0, 4'h0, 4'h0, 4'h0));
        dip_i = 4'b0001;
        tick();
        check("thr4_pre5", o, e(4'h1, 4'h0, 4'h0, 4'h0, 4'h0));
        tick();
        check("thr4_acc", o, e(4'b0011, 4'h0, 4'h0, 4'h0, 4'b0010));
        tick(3);
        check("thr4_hold", o, e(4'b0011, 4'h0, 4'h0, 4'h0, 4'h0));
        tick();
        check("thr4_back", o, e(4'b0001, 4'h0, 4'h0, 4'h0, 4'b0010));
        tick();
        check("thr4_done", o, e(4'b0001, 4'h0, 4'h0, 4'h0, 4'h0));
        dip_i = 4'b1110;
        push_i = 4'h0;
        tick(5);
        check("all_pre", o, e(4'b0001, 4'h0, 4'h0, 4'h0, 4'h0));
        tick();
        check("all_acc", o, e(4'b1110, 4'hF, 4'hF, 4'h0, 4'hF));
        tick();
        check("all_post", o, e(4'b1110, 4'hF, 4'h0, 4'h0, 4'h0));
        push_i = 4'hF;
        tick(6);
        check("all_rel", o, e(4'b1110, 4'h0, 4'h0, 4'hF, 4'h0));
        tick(4);
        push_i = 4'b1101;
        tick(4);
        check("mid_pre", o, e(4'b1110, 4'h0, 4'h0, 4'h0, 4'h0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst", o, '0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mid_wait", o, '0);
        end
        tick();
        check("mid_acc", o, e(4'b1110, 4'b0010, 4'b0010, 4'h0, 4'b1110));
        tick();
        check("mid_post", o, e(4'b1110, 4'b0010, 4'h0, 4'h0, 4'h0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
